// File: rtl/ram_arbiter_clear_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_clear_if
//
// Purpose : Access channel between one client block and the RAM arbiter.
//           Each requester (A, B) gets its own instance of this bundle.
//
// Signals :
//   req    client -> arbiter  access request, held until gnt
//   we     client -> arbiter  1 = write, 0 = read (qualified by req)
//   addr   client -> arbiter  word address
//   wdata  client -> arbiter  write data
//   gnt    arbiter -> client  access issued this cycle (combinational)
//   rvalid arbiter -> client  rdata carries this client's read result
//   rdata  arbiter -> client  shared RAM read data (no reset)
//
// Modports: master = client side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ram_arbiter_clear_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter_clear.sv
// ----------------------------------------------------------------------------
// ram_arbiter_clear
//
// Purpose : Round-robin arbiter and zero-fill sequencer in front of one
//           single-port synchronous RAM (registered read, 1-cycle latency).
//           Two requesters share the RAM with at most one access per cycle.
//           After reset the whole RAM can optionally be cleared to zero
//           before any request is accepted.
//
// Ports   :
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   port_a    requester A channel (slave modport)
//   port_b    requester B channel (slave modport)
//   busy      high while the zero-fill sequence runs
//   ram_we    RAM write enable
//   ram_addr  RAM address
//   ram_d     RAM write data
//   ram_q     RAM registered read data (forwarded to both rdata outputs)
// ----------------------------------------------------------------------------
module ram_arbiter_clear #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_arbiter_clear_if.slave    port_a,
  ram_arbiter_clear_if.slave    port_b,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  // Last address written by the zero-fill sequence.
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  // Round-robin pointer encoding: which side wins the next tie.
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q,   clr_cnt_d;
  logic                  prio_q,      prio_d;
  logic                  rvalid_a_q,  rvalid_a_d;
  logic                  rvalid_b_q,  rvalid_b_d;

  logic                  gnt_a;
  logic                  gnt_b;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      prio_q     <= PRIO_A;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      prio_q     <= prio_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        // The write to the last word goes out this cycle; requests are
        // accepted from the following cycle on.
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values: clear counter, round-robin pointer, read valids
  // --------------------------------------------------------------------------
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      // Wraps back to zero after the last word, ready for a later reset.
      clr_cnt_d = clr_cnt_q + 1'b1;
    end

    // The side just served loses the next tie.
    prio_d = prio_q;
    if (gnt_a) begin
      prio_d = PRIO_B;
    end else if (gnt_b) begin
      prio_d = PRIO_A;
    end

    // The RAM returns read data one cycle after the address is presented,
    // so the valid flag is simply the read grant delayed by one register.
    rvalid_a_d = gnt_a & ~port_a.we;
    rvalid_b_d = gnt_b & ~port_b.we;
  end

  // --------------------------------------------------------------------------
  // Output logic: grants and RAM port steering
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    busy     = (state_q == ST_CLEAR);

    // Nothing reaches the RAM while reset is held, even though the state
    // register has not yet been re-initialised in the first reset cycle.
    if (!reset) begin
      case (state_q)
        ST_CLEAR: begin
          ram_we   = 1'b1;
          ram_addr = clr_cnt_q;
        end
        ST_RUN: begin
          gnt_a = port_a.req & (~port_b.req | (prio_q == PRIO_A));
          gnt_b = port_b.req & (~port_a.req | (prio_q == PRIO_B));
          if (gnt_a) begin
            ram_we   = port_a.we;
            ram_addr = port_a.addr;
            ram_d    = port_a.wdata;
          end else if (gnt_b) begin
            ram_we   = port_b.we;
            ram_addr = port_b.addr;
            ram_d    = port_b.wdata;
          end
        end
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end
  end

  assign port_a.gnt    = gnt_a;
  assign port_b.gnt    = gnt_b;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.rvalid = rvalid_b_q;

  // Read data is shared; each client qualifies it with its own rvalid.
  assign port_a.rdata  = ram_q;
  assign port_b.rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter_clear.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter_clear
//
// Bench for ram_arbiter_clear. Two instances: one with the zero-fill enabled
// and one without. Each drives a behavioural RAM with registered read.
// Expected read data is taken from a shadow memory kept by the bench and
// queued at the moment the read is granted, then popped when rvalid is due.
// ----------------------------------------------------------------------------
module tb_ram_arbiter_clear;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          reset2;
  logic          preload;

  logic          busy,  ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  logic          busy2, ram_we2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_d2, ram_q2;

  ram_arbiter_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pa ();
  ram_arbiter_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pb ();
  ram_arbiter_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pa2 ();
  ram_arbiter_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pb2 ();

  ram_arbiter_clear #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .port_a(pa), .port_b(pb),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d),
    .ram_q(ram_q)
  );

  ram_arbiter_clear #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)
  ) dut_nc (
    .clk(clk), .reset(reset2), .port_a(pa2), .port_b(pb2),
    .busy(busy2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_d(ram_d2),
    .ram_q(ram_q2)
  );

  // Behavioural RAMs. The first can be filled with a non-zero pattern so the
  // zero-fill has something visible to overwrite.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | DW'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_d;
    end
    ram_q <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_we2) mem2[ram_addr2] <= ram_d2;
    ram_q2 <= mem2[ram_addr2];
  end

  // Bench bookkeeping
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    bit            side;   // 0 = A, 1 = B
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string         lbl;
    logic          rst;
    logic          ra, wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb, wb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          ega, egb;
  } step_t;

  typedef struct {
    logic          rva, rvb;
    logic [DW-1:0] rda, rdb;
    logic          ga, gb, we, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
  } obs_t;

  function automatic step_t mk(string lbl, logic rst,
                               logic ra, logic wa, logic [AW-1:0] aa, logic [DW-1:0] da,
                               logic rb, logic wb, logic [AW-1:0] ab, logic [DW-1:0] db,
                               logic ega, logic egb);
    step_t s;
    s.lbl = lbl; s.rst = rst;
    s.ra = ra; s.wa = wa; s.aa = aa; s.da = da;
    s.rb = rb; s.wb = wb; s.ab = ab; s.db = db;
    s.ega = ega; s.egb = egb;
    return s;
  endfunction

  // One clock cycle on the main instance: registered outputs are captured
  // just after the edge, then inputs are applied and the combinational
  // outputs are captured once they settle.
  task automatic cyc(input step_t s, output obs_t o);
    @(posedge clk);
    #1;
    o.rva = pa.rvalid; o.rvb = pb.rvalid;
    o.rda = pa.rdata;  o.rdb = pb.rdata;
    reset    = s.rst;
    pa.req   = s.ra; pa.we = s.wa; pa.addr = s.aa; pa.wdata = s.da;
    pb.req   = s.rb; pb.we = s.wb; pb.addr = s.ab; pb.wdata = s.db;
    #1;
    o.ga = pa.gnt; o.gb = pb.gnt; o.we = ram_we; o.busy = busy;
    o.addr = ram_addr; o.d = ram_d;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    obs_t  o;
    exp_t  e;
    step_t s;
    preload = 1'b1;
    s = mk("reset", 1'b1, 1'b1, 1'b0, 7'h05, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(s, o);
      checks++;
      if (o.ga !== 1'b0 || o.gb !== 1'b0 || o.we !== 1'b0) begin
        failures++;
        $display("FAIL reset_gate cycle %0d: gnt_a=%b gnt_b=%b ram_we=%b, required 0 0 0",
                 i, o.ga, o.gb, o.we);
      end
    end
    checks++;
    if (o.busy !== 1'b1 || o.rva !== 1'b0 || o.rvb !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b rvalid_a=%b rvalid_b=%b, required 1 0 0",
               o.busy, o.rva, o.rvb);
    end
    preload = 1'b0;

    s.rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(s, o);
      checks++;
      if (o.busy !== 1'b1 || o.we !== 1'b1 || o.addr !== AW'(i) || o.d !== '0 ||
          o.ga !== 1'b0 || o.gb !== 1'b0) begin
        failures++;
        $display("FAIL clear_step %0d: busy=%b ram_we=%b ram_addr=%0d ram_d=%h gnt_a=%b gnt_b=%b, required 1 1 %0d 0 0 0",
                 i, o.busy, o.we, o.addr, o.d, o.ga, o.gb, i);
      end
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    s = mk("first_read", 1'b0, 1'b1, 1'b0, 7'h05, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(s, o);
    checks++;
    if (o.busy !== 1'b0 || o.ga !== 1'b1 || o.we !== 1'b0 || o.addr !== 7'h05) begin
      failures++;
      $display("FAIL first_grant: busy=%b gnt_a=%b ram_we=%b ram_addr=%h, required 0 1 0 05",
               o.busy, o.ga, o.we, o.addr);
    end
    sb_q.push_back('{1'b0, ref_mem[5]});

    s = mk("idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(s, o);
    e = sb_q.pop_front();
    checks++;
    if (o.rva !== 1'b1 || o.rvb !== 1'b0 || o.rda !== e.data) begin
      failures++;
      $display("FAIL first_read_data: rvalid_a=%b rvalid_b=%b rdata=%h, required 1 0 %h",
               o.rva, o.rvb, o.rda, e.data);
    end
  endtask

  // --------------------------------------------------------------------------
  // RUN-state traffic: lone requester, contention, write/read interleave.
  task automatic test_run_traffic();
    step_t         st[$];
    obs_t          o;
    exp_t          e;
    logic          exp_rva, exp_rvb;
    logic [DW-1:0] exp_d;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;

    // A alone: write then read back the same address on consecutive cycles
    st.push_back(mk("a_alone", 1'b0, 1'b1, 1'b1, 7'h12, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    st.push_back(mk("a_alone", 1'b0, 1'b1, 1'b0, 7'h12, '0,           1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
    st.push_back(mk("a_alone", 1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    // B alone: its grant hands the tie-break back to A
    st.push_back(mk("b_alone", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h20, 32'hB0B00001, 1'b0, 1'b1));
    // Both requesting every cycle: A,B,A,B,A,B
    for (int k = 0; k < 6; k++) begin
      st.push_back(mk("contention", 1'b0, 1'b1, 1'b0, 7'h20, '0, 1'b1, 1'b0, 7'h12, '0,
                      (k % 2 == 0), (k % 2 == 1)));
    end
    st.push_back(mk("contention", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    // A writes 0x7F while B wants to read it: A first, B next, new data
    st.push_back(mk("interleave", 1'b0, 1'b1, 1'b1, 7'h7F, 32'h12345678, 1'b1, 1'b0, 7'h7F, '0, 1'b1, 1'b0));
    st.push_back(mk("interleave", 1'b0, 1'b0, 1'b0, '0,    '0,           1'b1, 1'b0, 7'h7F, '0, 1'b0, 1'b1));
    st.push_back(mk("interleave", 1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0, '0,    '0, 1'b0, 1'b0));

    foreach (st[i]) begin
      cyc(st[i], o);

      exp_rva = 1'b0; exp_rvb = 1'b0; exp_d = '0;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_rva = (e.side == 1'b0);
        exp_rvb = (e.side == 1'b1);
        exp_d   = e.data;
      end
      checks++;
      if (o.rva !== exp_rva || o.rvb !== exp_rvb) begin
        failures++;
        $display("FAIL rvalid [%s step %0d]: rvalid_a=%b rvalid_b=%b, required %b %b",
                 st[i].lbl, i, o.rva, o.rvb, exp_rva, exp_rvb);
      end
      if (exp_rva || exp_rvb) begin
        checks++;
        if ((exp_rva ? o.rda : o.rdb) !== exp_d) begin
          failures++;
          $display("FAIL rdata [%s step %0d]: rdata=%h, required %h",
                   st[i].lbl, i, exp_rva ? o.rda : o.rdb, exp_d);
        end
      end

      checks++;
      if (o.ga !== st[i].ega || o.gb !== st[i].egb || o.busy !== 1'b0) begin
        failures++;
        $display("FAIL grant [%s step %0d]: gnt_a=%b gnt_b=%b busy=%b, required %b %b 0",
                 st[i].lbl, i, o.ga, o.gb, o.busy, st[i].ega, st[i].egb);
      end

      exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      if (st[i].ega) begin
        exp_we = st[i].wa; exp_addr = st[i].aa; exp_wd = st[i].da;
      end else if (st[i].egb) begin
        exp_we = st[i].wb; exp_addr = st[i].ab; exp_wd = st[i].db;
      end
      checks++;
      if (o.we !== exp_we || o.addr !== exp_addr || o.d !== exp_wd) begin
        failures++;
        $display("FAIL ram_port [%s step %0d]: ram_we=%b ram_addr=%h ram_d=%h, required %b %h %h",
                 st[i].lbl, i, o.we, o.addr, o.d, exp_we, exp_addr, exp_wd);
      end

      // Bench-side memory and read scoreboard follow the expected grant.
      if (st[i].ega) begin
        if (st[i].wa) ref_mem[st[i].aa] = st[i].da;
        else          sb_q.push_back('{1'b0, ref_mem[st[i].aa]});
      end else if (st[i].egb) begin
        if (st[i].wb) ref_mem[st[i].ab] = st[i].db;
        else          sb_q.push_back('{1'b1, ref_mem[st[i].ab]});
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_clear();
    obs_t  o;
    exp_t  e;
    step_t s;

    s = mk("rst_run", 1'b1, 1'b1, 1'b0, 7'h12, '0, 1'b1, 1'b0, 7'h20, '0, 1'b0, 1'b0);
    cyc(s, o);
    checks++;
    if (o.ga !== 1'b0 || o.gb !== 1'b0 || o.we !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_run: gnt_a=%b gnt_b=%b ram_we=%b, required 0 0 0", o.ga, o.gb, o.we);
    end

    s.rst = 1'b0; s.rb = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(s, o);
      checks++;
      if (o.busy !== 1'b1 || o.we !== 1'b1 || o.addr !== AW'(i) || o.ga !== 1'b0 ||
          o.rva !== 1'b0 || o.rvb !== 1'b0) begin
        failures++;
        $display("FAIL partial_clear %0d: busy=%b ram_we=%b ram_addr=%0d gnt_a=%b rvalid=%b%b, required 1 1 %0d 0 00",
                 i, o.busy, o.we, o.addr, o.ga, o.rva, o.rvb, i);
      end
    end

    s.rst = 1'b1;
    cyc(s, o);
    checks++;
    if (o.ga !== 1'b0 || o.gb !== 1'b0 || o.we !== 1'b0 || o.rva !== 1'b0 || o.rvb !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: gnt=%b%b ram_we=%b rvalid=%b%b, required 00 0 00",
               o.ga, o.gb, o.we, o.rva, o.rvb);
    end

    s.rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(s, o);
      checks++;
      if (o.busy !== 1'b1 || o.we !== 1'b1 || o.addr !== AW'(i) || o.d !== '0 || o.ga !== 1'b0) begin
        failures++;
        $display("FAIL reclear_step %0d: busy=%b ram_we=%b ram_addr=%0d ram_d=%h gnt_a=%b, required 1 1 %0d 0 0",
                 i, o.busy, o.we, o.addr, o.d, o.ga, i);
      end
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    s = mk("reread", 1'b0, 1'b1, 1'b0, 7'h12, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(s, o);
    checks++;
    if (o.busy !== 1'b0 || o.ga !== 1'b1 || o.addr !== 7'h12) begin
      failures++;
      $display("FAIL reclear_grant: busy=%b gnt_a=%b ram_addr=%h, required 0 1 12", o.busy, o.ga, o.addr);
    end
    sb_q.push_back('{1'b0, ref_mem[7'h12]});

    s = mk("idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(s, o);
    e = sb_q.pop_front();
    checks++;
    if (o.rva !== 1'b1 || o.rvb !== 1'b0 || o.rda !== e.data) begin
      failures++;
      $display("FAIL reclear_data: rvalid_a=%b rvalid_b=%b rdata=%h, required 1 0 %h",
               o.rva, o.rvb, o.rda, e.data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_no_clear();
    exp_t e;
    @(posedge clk);
    #1;
    pa2.req = 1'b1; pa2.we = 1'b1; pa2.addr = 7'h03; pa2.wdata = 32'hCAFE0003;
    #1;
    checks++;
    if (pa2.gnt !== 1'b0 || ram_we2 !== 1'b0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL nc_reset: gnt_a=%b ram_we=%b busy=%b, required 0 0 0", pa2.gnt, ram_we2, busy2);
    end

    @(posedge clk);
    #1;
    reset2 = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || pa2.gnt !== 1'b1 || ram_we2 !== 1'b1 ||
        ram_addr2 !== 7'h03 || ram_d2 !== 32'hCAFE0003) begin
      failures++;
      $display("FAIL nc_first_grant: busy=%b gnt_a=%b ram_we=%b ram_addr=%h ram_d=%h, required 0 1 1 03 cafe0003",
               busy2, pa2.gnt, ram_we2, ram_addr2, ram_d2);
    end

    @(posedge clk);
    #1;
    pa2.we = 1'b0;
    #1;
    checks++;
    if (pa2.gnt !== 1'b1 || ram_we2 !== 1'b0) begin
      failures++;
      $display("FAIL nc_read_grant: gnt_a=%b ram_we=%b, required 1 0", pa2.gnt, ram_we2);
    end
    sb_q.push_back('{1'b0, 32'hCAFE0003});

    @(posedge clk);
    #1;
    pa2.req = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (pa2.rvalid !== 1'b1 || pb2.rvalid !== 1'b0 || pa2.rdata !== e.data) begin
      failures++;
      $display("FAIL nc_read_data: rvalid_a=%b rvalid_b=%b rdata=%h, required 1 0 %h",
               pa2.rvalid, pb2.rvalid, pa2.rdata, e.data);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    reset   = 1'b1;
    reset2  = 1'b1;
    preload = 1'b0;
    pa.req  = 1'b0; pa.we  = 1'b0; pa.addr  = '0; pa.wdata  = '0;
    pb.req  = 1'b0; pb.we  = 1'b0; pb.addr  = '0; pb.wdata  = '0;
    pa2.req = 1'b0; pa2.we = 1'b0; pa2.addr = '0; pa2.wdata = '0;
    pb2.req = 1'b0; pb2.we = 1'b0; pb2.addr = '0; pb2.wdata = '0;

    test_reset();
    test_run_traffic();
    test_reset_mid_clear();
    test_no_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
